// File: rtl/cache_pkg.sv
// ============================================================================
// Module      : cache_pkg
// Description : Shared constants, line record and address-field helpers for
//               the 2-way set-associative read cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

    localparam int INDEX_W_DEFAULT = 6;
    localparam int ADDR_USED_W     = 18;
    localparam int TAG_W_DEFAULT   = ADDR_USED_W - 3 - INDEX_W_DEFAULT;
    localparam int SETS_DEFAULT    = 2 ** INDEX_W_DEFAULT;
    // Widest tag possible (one index bit); narrower tags are zero-extended.
    localparam int TAG_MAX_W       = ADDR_USED_W - 3 - 1;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          data0;
        logic [31:0]          data1;
    } line_t;

    function automatic logic addr_word(input logic [ADDR_USED_W-1:0] a);
        return 1'((a >> 2) & 18'd1);
    endfunction

    function automatic logic [TAG_MAX_W:0] addr_index(input logic [ADDR_USED_W-1:0] a);
        return (TAG_MAX_W + 1)'(a >> 3);
    endfunction

    function automatic logic [TAG_MAX_W-1:0] addr_tag(input logic [ADDR_USED_W-1:0] a,
                                                      input int index_w);
        return TAG_MAX_W'(a >> (3 + index_w));
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_way.sv
// ============================================================================
// Module      : cache_way
// Description : One way of the cache: per-set valid/tag/data storage with the
//               tag compare for the currently addressed set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_way
    import cache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEFAULT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [INDEX_W-1:0]                 index,
    input  logic [ADDR_USED_W-3-INDEX_W-1:0]   tag,
    input  logic                               fill_en,
    input  logic                               inv_en,
    input  logic [31:0]                        fill_word0,
    input  logic [31:0]                        fill_word1,
    output logic                               valid,
    output logic                               match,
    output logic [31:0]                        data0,
    output logic [31:0]                        data1
);

    localparam int TAG_W = ADDR_USED_W - 3 - INDEX_W;
    localparam int SETS  = 2 ** INDEX_W;

    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  valid_d;
    logic [TAG_W-1:0] tag_q   [SETS];
    logic [31:0]      data0_q [SETS];
    logic [31:0]      data1_q [SETS];
    line_t            cur_line;

    always_comb begin
        valid_d = valid_q;
        if (fill_en) begin
            valid_d[index] = 1'b1;
        end else if (inv_en) begin
            valid_d[index] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data need no reset: they are qualified by valid.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[index]   <= tag;
            data0_q[index] <= fill_word0;
            data1_q[index] <= fill_word1;
        end
    end

    always_comb begin
        cur_line.valid = valid_q[index];
        cur_line.tag   = TAG_MAX_W'(tag_q[index]);
        cur_line.data0 = data0_q[index];
        cur_line.data1 = data1_q[index];
    end

    assign valid = cur_line.valid;
    assign match = cur_line.valid && (cur_line.tag == TAG_MAX_W'(tag));
    assign data0 = cur_line.data0;
    assign data1 = cur_line.data1;

endmodule

`default_nettype wire

// File: rtl/cache_ctrl.sv
// ============================================================================
// Module      : cache_ctrl
// Description : 2-way set-associative, write-through/invalidate read cache.
//               Optional hit/miss counters enabled by defining CACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_ctrl
    import cache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic        fill_en,
    input  logic [31:0] fill_word0,
    input  logic [31:0] fill_word1,
    output logic        hit,
    output logic [31:0] rd_data,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int TAG_W = ADDR_USED_W - 3 - INDEX_W;
    localparam int SETS  = 2 ** INDEX_W;

    logic [ADDR_USED_W-1:0] addr_used;
    logic                   unused_addr_hi;
    logic                   word_sel;
    logic [INDEX_W-1:0]     index;
    logic [TAG_W-1:0]       tag;

    assign addr_used      = addr[ADDR_USED_W-1:0];
    assign unused_addr_hi = ^addr[31:ADDR_USED_W];
    assign word_sel       = addr_word(addr_used);
    assign index          = INDEX_W'(addr_index(addr_used));
    assign tag            = TAG_W'(addr_tag(addr_used, INDEX_W));

    logic [1:0]  way_valid;
    logic [1:0]  way_match;
    logic [1:0]  way_fill;
    logic [1:0]  way_inv;
    logic [31:0] way_data0 [2];
    logic [31:0] way_data1 [2];

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way #(
            .INDEX_W    (INDEX_W)
        ) u_way (
            .clk        (clk),
            .rst        (rst),
            .index      (index),
            .tag        (tag),
            .fill_en    (way_fill[w]),
            .inv_en     (way_inv[w]),
            .fill_word0 (fill_word0),
            .fill_word1 (fill_word1),
            .valid      (way_valid[w]),
            .match      (way_match[w]),
            .data0      (way_data0[w]),
            .data1      (way_data1[w])
        );
    end

    logic [SETS-1:0] lru_q;
    logic [SETS-1:0] lru_d;
    logic            is_read;
    logic            hit_way;
    logic            victim;

    assign is_read = rd_en & ~wr_en;
    assign hit     = is_read & (|way_match);
    // Way0 wins if both ever match; victim reuses a matching way to avoid duplicates.
    assign hit_way = ~way_match[0];
    assign rd_data = hit ? (word_sel ? way_data1[hit_way] : way_data0[hit_way]) : 32'd0;

    always_comb begin
        if (way_match[0]) begin
            victim = 1'b0;
        end else if (way_match[1]) begin
            victim = 1'b1;
        end else if (!way_valid[0]) begin
            victim = 1'b0;
        end else if (!way_valid[1]) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[index];
        end
    end

    always_comb begin
        way_fill = 2'b00;
        way_inv  = 2'b00;
        lru_d    = lru_q;
        if (fill_en) begin
            way_fill[victim] = 1'b1;
            lru_d[index]     = ~victim;
        end else if (wr_en) begin
            way_inv = way_match;
            if (|way_match) begin
                lru_d[index] = hit_way;
            end
        end else if (hit) begin
            lru_d[index] = ~hit_way;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru_q <= '0;
        end else begin
            lru_q <= lru_d;
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count_q;
    logic [15:0] hit_count_d;
    logic [15:0] miss_count_q;
    logic [15:0] miss_count_d;

    // A stalled load retries every cycle, so misses are counted per cycle.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit && (hit_count_q != 16'hFFFF)) begin
            hit_count_d = hit_count_q + 16'd1;
        end
        if (is_read && !hit && !fill_en && (miss_count_q != 16'hFFFF)) begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= 16'd0;
            miss_count_q <= 16'd0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

endmodule

`default_nettype wire
